// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the ram_32x8 two-port arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  // Sequencer states: arbitrate, drive the RAM, wait for registered dout, return data.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RDRET  = 2'd3
  } arb_state_t;

  // Requester identity, used for the winner and the round-robin pointer.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

endpackage

// File: rtl/ram_arb_rr2.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on a tie the port that was not granted last wins.
module ram_arb_rr2
  import ram_arb_pkg::*;
(
  input  logic     req_a,
  input  logic     req_b,
  input  port_id_t last,
  output port_id_t sel,
  output logic     any
);

  // Pick the winner from the current requests and the last-granted pointer
  always_comb begin
    any = req_a | req_b;
    sel = PORT_A;
    if (req_a && req_b) begin
      sel = (last == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      sel = PORT_B;
    end
  end

endmodule

// File: rtl/ram_32x8_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared ram_32x8.
//
// Handshake: a requester raises req_x with we/addr/wdata stable and holds it
// until gnt_x; gnt_x is a one-cycle pulse meaning the command is on the RAM
// pins this cycle; the requester drops req_x afterwards. Requests are only
// sampled in IDLE. Reads return data with a one-cycle rvalid_x pulse two
// cycles after gnt_x; rdata_x holds its value otherwise.
module ram_32x8_arbiter #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_a,
  input  logic                    req_b,
  input  logic                    we_a,
  input  logic                    we_b,
  input  logic [ADDR_W-1:0]       addr_a,
  input  logic [ADDR_W-1:0]       addr_b,
  input  logic [DATA_W-1:0]       wdata_a,
  input  logic [DATA_W-1:0]       wdata_b,
  output logic                    gnt_a,
  output logic                    gnt_b,
  output logic                    rvalid_a,
  output logic                    rvalid_b,
  output logic [DATA_W-1:0]       rdata_a,
  output logic [DATA_W-1:0]       rdata_b,
  output logic                    busy,
  output logic                    ram_rd,
  output logic                    ram_wr,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_data,
  input  logic [DATA_W-1:0]       ram_dout,
  output ram_arb_pkg::arb_state_t o_dbg_state
);

  import ram_arb_pkg::*;

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  port_id_t            r_last;
  port_id_t            r_winner;
  logic                r_we;
  port_id_t            w_sel;
  logic                w_any;
  logic                w_take;
  logic                w_cmd_we;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic [DATA_W-1:0]   w_cmd_wdata;

  logic                r_gnt_a;
  logic                r_gnt_b;
  logic                r_rvalid_a;
  logic                r_rvalid_b;
  logic [DATA_W-1:0]   r_rdata_a;
  logic [DATA_W-1:0]   r_rdata_b;
  logic                r_busy;
  logic                r_ram_rd;
  logic                r_ram_wr;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data;

  ram_arb_rr2 u_rr2 (
    .req_a (req_a),
    .req_b (req_b),
    .last  (r_last),
    .sel   (w_sel),
    .any   (w_any)
  );

  // Route the winning port's command fields toward the issue registers
  always_comb begin
    w_cmd_we    = (w_sel == PORT_A) ? we_a    : we_b;
    w_cmd_addr  = (w_sel == PORT_A) ? addr_a  : addr_b;
    w_cmd_wdata = (w_sel == PORT_A) ? wdata_a : wdata_b;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; w_take marks the IDLE cycle in which a command is accepted
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take       = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE:   w_next_state = r_we ? IDLE : RDWAIT;
      RDWAIT:  w_next_state = RDRET;
      RDRET:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Winner, round-robin pointer and command type; the RAM address/data
  // registers below double as the command's address/data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last   <= PORT_B;
      r_winner <= PORT_A;
      r_we     <= 1'b0;
    end else if (w_take) begin
      r_last   <= w_sel;
      r_winner <= w_sel;
      r_we     <= w_cmd_we;
    end
  end

  // Registered outputs: grant and RAM strobes during ISSUE, data return in RDRET
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_busy     <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
    end else begin
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_busy     <= (w_next_state != IDLE);
      if (w_take) begin
        r_gnt_a    <= (w_sel == PORT_A);
        r_gnt_b    <= (w_sel == PORT_B);
        r_ram_wr   <= w_cmd_we;
        r_ram_rd   <= ~w_cmd_we;
        r_ram_addr <= w_cmd_addr;
        r_ram_data <= w_cmd_we ? w_cmd_wdata : '0;
      end
      // RAM dout is valid during RDWAIT; only the winner's rdata is touched
      if (r_state == RDWAIT) begin
        if (r_winner == PORT_A) begin
          r_rdata_a  <= ram_dout;
          r_rvalid_a <= 1'b1;
        end else begin
          r_rdata_b  <= ram_dout;
          r_rvalid_b <= 1'b1;
        end
      end
    end
  end

  assign gnt_a       = r_gnt_a;
  assign gnt_b       = r_gnt_b;
  assign rvalid_a    = r_rvalid_a;
  assign rvalid_b    = r_rvalid_b;
  assign rdata_a     = r_rdata_a;
  assign rdata_b     = r_rdata_b;
  assign busy        = r_busy;
  assign ram_rd      = r_ram_rd;
  assign ram_wr      = r_ram_wr;
  assign ram_addr    = r_ram_addr;
  assign ram_data    = r_ram_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_32x8_arbiter.sv
// Bench for ram_32x8_arbiter: directed scenarios followed by random traffic,
// with a RAM model, per-port requester agents and a transaction-level reference.
module tb_ram_32x8_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_rd, ram_wr;
  logic [DW-1:0] rdata_a, rdata_b, ram_data, ram_dout;
  logic [AW-1:0] ram_addr;
  arb_state_t    dbg_state;

  ram_32x8_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_dout(ram_dout), .o_dbg_state(dbg_state)
  );

  // Single-port RAM with registered dout
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_data;
    if (ram_rd) ram_dout <= mem[ram_addr];
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  bit mon_en = 1'b0;

  cmd_t          q_a[$], q_b[$];
  logic [DW-1:0] exp_q_a[$], exp_q_b[$];
  int unsigned   due_q_a[$], due_q_b[$];
  port_id_t      gnt_log[$];
  logic [DW-1:0] ref_mem [32];
  port_id_t      m_last;
  logic [DW-1:0] m_rdata_a, m_rdata_b;

  logic p_rst, p_req_a, p_req_b;
  cmd_t p_cmd_a, p_cmd_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  // ---------------- driver agents ----------------
  always begin : agent_a
    @(negedge clk);
    if (gnt_a && req_a) begin req_a = 1'b0; q_a.delete(0); end
    @(posedge clk); #1;
    if (!req_a && q_a.size() > 0) begin
      we_a = q_a[0].we; addr_a = q_a[0].addr; wdata_a = q_a[0].wdata; req_a = 1'b1;
    end
  end

  always begin : agent_b
    @(negedge clk);
    if (gnt_b && req_b) begin req_b = 1'b0; q_b.delete(0); end
    @(posedge clk); #1;
    if (!req_b && q_b.size() > 0) begin
      we_b = q_b[0].we; addr_b = q_b[0].addr; wdata_b = q_b[0].wdata; req_b = 1'b1;
    end
  end

  // Capture what the arbiter saw at each rising edge
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    p_rst   <= reset;
    p_req_a <= req_a;
    p_req_b <= req_b;
    p_cmd_a <= mk(we_a, addr_a, wdata_a);
    p_cmd_b <= mk(we_b, addr_b, wdata_b);
  end

  // ---------------- scoreboard / reference model ----------------
  always @(negedge clk) begin : mon
    port_id_t ew, gp;
    cmd_t     c;
    if (mon_en) begin
      if (p_rst) begin
        exp_q_a.delete(); exp_q_b.delete(); due_q_a.delete(); due_q_b.delete();
        m_last = PORT_B; m_rdata_a = '0; m_rdata_b = '0;
        check("reset_ctrl", 64'({gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_rd, ram_wr}), 64'(0));
        check("reset_data", 64'({ram_addr, ram_data, rdata_a, rdata_b}), 64'(0));
      end else begin
        check("rd_wr_excl", 64'(ram_rd & ram_wr), 64'(0));
        check("gnt_excl", 64'(gnt_a & gnt_b), 64'(0));
        check("strobe_iff_gnt", 64'(ram_rd | ram_wr), 64'(gnt_a | gnt_b));
        if (gnt_a || gnt_b) begin
          gp = gnt_b ? PORT_B : PORT_A;
          if (!p_req_a && !p_req_b) check("gnt_has_req", 64'(0), 64'(1));
          else begin
            if (p_req_a && p_req_b) ew = (m_last == PORT_A) ? PORT_B : PORT_A;
            else ew = p_req_a ? PORT_A : PORT_B;
            check("winner", 64'(gp), 64'(ew));
          end
          check("busy_on_gnt", 64'(busy), 64'(1));
          c = (gp == PORT_A) ? p_cmd_a : p_cmd_b;
          check("ram_wr", 64'(ram_wr), 64'(c.we));
          check("ram_rd", 64'(ram_rd), 64'(!c.we));
          check("ram_addr", 64'(ram_addr), 64'(c.addr));
          check("ram_data", 64'(ram_data), c.we ? 64'(c.wdata) : 64'(0));
          m_last = gp;
          gnt_log.push_back(gp);
          if (c.we) ref_mem[c.addr] = c.wdata;
          else if (gp == PORT_A) begin exp_q_a.push_back(ref_mem[c.addr]); due_q_a.push_back(cyc + 2); end
          else begin exp_q_b.push_back(ref_mem[c.addr]); due_q_b.push_back(cyc + 2); end
        end
        // port A return path
        if (rvalid_a) begin
          check("busy_on_rvalid_a", 64'(busy), 64'(1));
          if (exp_q_a.size() == 0) check("rvalid_a_unexpected", 64'(1), 64'(0));
          else begin
            check("rdata_a", 64'(rdata_a), 64'(exp_q_a[0]));
            check("rvalid_a_time", 64'(cyc), 64'(due_q_a[0]));
            m_rdata_a = exp_q_a[0];
            exp_q_a.delete(0); due_q_a.delete(0);
          end
        end else check("rdata_a_hold", 64'(rdata_a), 64'(m_rdata_a));
        if (exp_q_a.size() > 0 && cyc > due_q_a[0]) begin
          check("rvalid_a_missing", 64'(0), 64'(1));
          exp_q_a.delete(0); due_q_a.delete(0);
        end
        // port B return path
        if (rvalid_b) begin
          check("busy_on_rvalid_b", 64'(busy), 64'(1));
          if (exp_q_b.size() == 0) check("rvalid_b_unexpected", 64'(1), 64'(0));
          else begin
            check("rdata_b", 64'(rdata_b), 64'(exp_q_b[0]));
            check("rvalid_b_time", 64'(cyc), 64'(due_q_b[0]));
            m_rdata_b = exp_q_b[0];
            exp_q_b.delete(0); due_q_b.delete(0);
          end
        end else check("rdata_b_hold", 64'(rdata_b), 64'(m_rdata_b));
        if (exp_q_b.size() > 0 && cyc > due_q_b[0]) begin
          check("rvalid_b_missing", 64'(0), 64'(1));
          exp_q_b.delete(0); due_q_b.delete(0);
        end
      end
    end
  end

  // ---------------- wait helpers ----------------
  // sel: 0 gnt_a, 1 gnt_b, 2 rvalid_a, 3 rvalid_b
  task automatic wait_for(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (sel)
        0: ok = gnt_a;
        1: ok = gnt_b;
        2: ok = rvalid_a;
        default: ok = rvalid_b;
      endcase
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      ok = (q_a.size() == 0) && (q_b.size() == 0) && !req_a && !req_b && !busy &&
           (exp_q_a.size() == 0) && (exp_q_b.size() == 0);
    end
  endtask

  function automatic logic [3:0] log_order();
    logic [3:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) if (i < gnt_log.size()) o[i] = gnt_log[i];
    return o;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    bit ok;
    int unsigned t0;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    ram_dout = '0;

    // Reset then idle
    reset = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_outs", 64'({gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_rd, ram_wr, ram_addr, ram_data}), 64'(0));
      check("idle_state", 64'(dbg_state), 64'(IDLE));
    end

    // Single write then read on port A
    q_a.push_back(mk(1'b1, 5'h03, 8'hA5));
    wait_for(0, 20, ok);
    check("wr_gnt_a", 64'(ok), 64'(1));
    check("wr_pins", 64'({ram_wr, ram_rd, ram_addr, ram_data}), 64'({1'b1, 1'b0, 5'h03, 8'hA5}));
    @(negedge clk);
    check("wr_one_cycle", 64'(ram_wr), 64'(0));
    q_a.push_back(mk(1'b0, 5'h03, 8'h00));
    wait_for(0, 20, ok);
    check("rd_gnt_a", 64'(ok), 64'(1));
    t0 = cyc;
    wait_for(2, 10, ok);
    check("rd_rvalid_a", 64'(ok), 64'(1));
    check("rd_latency", 64'(cyc - t0), 64'(2));
    check("rd_rdata_a", 64'(rdata_a), 64'(8'hA5));
    check("rd_rdata_b_kept", 64'(rdata_b), 64'(0));
    wait_idle(50, ok);
    check("single_drain", 64'(ok), 64'(1));

    // Seed distinct words for the tie test
    q_a.push_back(mk(1'b1, 5'h00, 8'h5A));
    q_b.push_back(mk(1'b1, 5'h01, 8'hC3));
    wait_idle(50, ok);
    check("seed_drain", 64'(ok), 64'(1));

    // Tie fairness after reset
    @(posedge clk); #1 reset = 1'b1;
    gnt_log.delete();
    for (int i = 0; i < 2; i++) begin
      q_a.push_back(mk(1'b0, 5'h00, 8'h00));
      q_b.push_back(mk(1'b0, 5'h01, 8'h00));
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_idle(100, ok);
    check("tie_drain", 64'(ok), 64'(1));
    check("tie_count", 64'(gnt_log.size()), 64'(4));
    check("tie_order", 64'(log_order()), 64'(4'b1010));
    check("tie_last_rdata_a", 64'(rdata_a), 64'(8'h5A));
    check("tie_last_rdata_b", 64'(rdata_b), 64'(8'hC3));

    // Mixed contention at the wrap address
    gnt_log.delete();
    q_a.push_back(mk(1'b1, 5'h1F, 8'h11));
    q_b.push_back(mk(1'b0, 5'h1F, 8'h00));
    wait_idle(100, ok);
    check("mixed_drain", 64'(ok), 64'(1));
    check("mixed_count", 64'(gnt_log.size()), 64'(2));
    check("mixed_order", 64'(log_order()), 64'(4'b0010));
    check("mixed_rdata_b", 64'(rdata_b), 64'(8'h11));

    // Reset during RDWAIT of a port B read
    q_b.push_back(mk(1'b0, 5'h02, 8'h00));
    wait_for(1, 20, ok);
    check("abort_gnt_b", 64'(ok), 64'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("abort_in_rdwait", 64'(dbg_state), 64'(RDWAIT));
    @(negedge clk);
    check("abort_rd_low", 64'(ram_rd), 64'(0));
    check("abort_no_rvalid", 64'(rvalid_b), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_late_rvalid", 64'(rvalid_b), 64'(0));
    end
    gnt_log.delete();
    q_a.push_back(mk(1'b0, 5'h00, 8'h00));
    q_b.push_back(mk(1'b0, 5'h01, 8'h00));
    wait_idle(100, ok);
    check("post_reset_drain", 64'(ok), 64'(1));
    check("post_reset_first", 64'(log_order() & 4'b0011), 64'(4'b0010));

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1)
        q_a.push_back(mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom_range(0, 255))));
      if ($urandom_range(0, 1) == 1)
        q_b.push_back(mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom_range(0, 255))));
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    wait_idle(3000, ok);
    check("random_drain", 64'(ok), 64'(1));
    check("exp_a_empty", 64'(exp_q_a.size()), 64'(0));
    check("exp_b_empty", 64'(exp_q_b.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_32x8_arbiter.md
# ram_32x8_arbiter

Two-port round-robin arbiter and access sequencer for the shared `ram_32x8` single-port memory. It sits between two independent requesters (port A, port B) and the RAM's `rd`/`wr`/`data`/`addr`/`dout` pins. It accepts one read or write command per grant and guarantees the RAM never sees `rd` and `wr` together. It returns read data to the requester that issued the read, with a valid pulse.

## Interface
Parameters:
- `ADDR_W`, 5: RAM address width (32 words).
- `DATA_W`, 8: RAM data width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_a`, `req_b`  in  1  access request; held high until `gnt_x`.
- `we_a`, `we_b`  in  1  1 = write, 0 = read.
- `addr_a`, `addr_b`  in  ADDR_W  target address.
- `wdata_a`, `wdata_b`  in  DATA_W  write data.
- `gnt_a`, `gnt_b`  out  1  one-cycle grant pulse; the command has been issued to the RAM.
- `rvalid_a`, `rvalid_b`  out  1  one-cycle read-data-valid pulse.
- `rdata_a`, `rdata_b`  out  DATA_W  read data; valid while `rvalid_x`=1, otherwise holds its last value.
- `busy`  out  1  high whenever the state is not IDLE.
- `ram_rd`, `ram_wr`  out  1  to RAM `rd`/`wr`.
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_data`  out  DATA_W  to RAM `data`.
- `ram_dout`  in  DATA_W  from RAM `dout`; registered in the RAM, valid the cycle after `rd` is sampled.

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, RDRET.
- **IDLE**
  - If any `req_x` is high, pick a winner and latch its `we`, `addr` and `wdata` into command registers. Latch the winner ID. Go to ISSUE.
  - If no request is high, stay in IDLE.
- **ISSUE**
  - Drive `ram_wr`=we or `ram_rd`=!we, plus `ram_addr` and `ram_data` from the command registers. `ram_data`=0 for reads.
  - Pulse `gnt_winner`.
  - Next state: IDLE for a write, RDWAIT for a read.
- **RDWAIT**
  - RAM strobes are low. Capture `ram_dout` into `rdata_winner`.
  - Next state: RDRET.
- **RDRET**
  - Pulse `rvalid_winner`. Next state: IDLE.
- **Round-robin selection**
  - A `last` pointer records the most recently granted port and updates on every grant.
  - If only one port requests, that port wins.
  - If both request in the same IDLE cycle, the port not equal to `last` wins.
- Requests arriving outside IDLE wait. The arbiter samples `req_x` only in IDLE.
- The requester must drop `req_x` in the cycle after `gnt_x`. If `req_x` is still high in a later IDLE cycle, it is a new request.
- `ram_rd` and `ram_wr` are never both 1.
- Exactly one `gnt_x` pulse and at most one `rvalid_x` pulse occur per command.
- The non-winning port's `rdata` is never modified.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE, `last`=B (so A wins the first tie).
  - `gnt_*`=0, `rvalid_*`=0, `rdata_*`=0, `busy`=0.
  - `ram_rd`=`ram_wr`=0, `ram_addr`=0, `ram_data`=0.
- Write: `req` is sampled at edge T. `gnt` and `ram_wr` are high in cycle T+1. The next arbitration happens at T+2. Throughput is one write per 2 cycles.
- Read: `req` is sampled at edge T. `gnt` and `ram_rd` are high in cycle T+1. `ram_dout` is captured at T+2 into `rdata`. `rdata` and `rvalid` are valid in cycle T+3. The next arbitration happens at T+4. Read latency is 3 cycles from request sample to `rvalid`.
- Reset asserted in any state returns everything to reset values on that edge. This includes:
  - An in-flight read is abandoned and no `rvalid` is issued.
  - RAM strobes drop immediately.
- `busy`=1 in ISSUE, RDWAIT and RDRET.

## Structure
- Shared package `ram_arb_pkg` contains:
  - `ADDR_W`/`DATA_W` defaults.
  - The state enum `arb_state_t` (IDLE, ISSUE, RDWAIT, RDRET).
  - The port-ID type `port_id_t` (PORT_A=0, PORT_B=1).
- Sub-module `ram_arb_rr2`: a combinational two-way round-robin picker.
  - Inputs: `req_a`, `req_b`, `last`.
  - Outputs: `sel`, `any`.
- The top module holds the FSM, the command and winner registers, and the output registers.

## Test plan
- Reset then idle: hold `reset`=1 for 2 cycles, then no requests for 10 cycles.
  - Required: all outputs stay 0 and `busy`=0 throughout.
- Single write/read, port A: write addr 5'h03, data 8'hA5. Then read addr 5'h03.
  - Required: `ram_wr`=1 with addr 03 and data A5 for exactly 1 cycle.
  - Required: `gnt_a` pulses.
  - Required: `rvalid_a` pulses 3 cycles after the read request is sampled, with `rdata_a`=8'hA5. `rdata_b` is unchanged.
- Tie fairness: both ports continuously request reads of 0x00 (A) and 0x01 (B) after reset.
  - Required: grants go A, B, A, B.
  - Required: each `rvalid` is returned to the matching port.
- Mixed contention: A writes 8'h11 to 0x1F while B reads 0x1F, both requesting in the same cycle.
  - Required: A is granted first, then B.
  - Required: `rdata_b`=8'h11, proving write-before-read ordering at the wrap address 31.
- Reset mid-read: B reads 0x02, and `reset` is asserted in the RDWAIT cycle.
  - Required: no `rvalid_b`.
  - Required: `ram_rd`=0 on the next cycle.
  - Required: the following A/B tie grants A.
- Protocol check throughout all tests:
  - Assert `ram_rd` & `ram_wr` is never 1.
  - Assert `gnt_a` & `gnt_b` is never 1.
  - Assert each grant of a read produces exactly one `rvalid`.
